// File: rtl/cla_pkg.sv
// Shared definitions for the iterative carry-lookahead add/subtract datapath.
package cla_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addsub_state_t;

    // Byte-index width; a single-slice configuration still needs one bit.
    function automatic int idx_width(input int nslice);
        if (nslice <= 1) begin
            return 1;
        end else begin
            return $clog2(nslice);
        end
    endfunction

endpackage

// File: rtl/cla_slice_8.sv
// Purely combinational 8-bit carry-lookahead adder slice.
// Also exposes the carry into bit 7 for signed-overflow detection.
module cla_slice_8
    import cla_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               c7
);

    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W:0]   w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Each carry is a flat sum of products of generate/propagate terms.
    always_comb begin
        logic acc;
        logic run_p;
        acc   = 1'b0;
        run_p = 1'b0;
        w_c   = {(SLICE_W+1){1'b0}};
        w_c[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            acc   = w_g[i];
            run_p = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc   = acc | (run_p & w_g[j]);
                run_p = run_p & w_p[j];
            end
            acc = acc | (run_p & cin);
            w_c[i+1] = acc;
        end
    end

    assign sum  = w_p ^ w_c[SLICE_W-1:0];
    assign cout = w_c[SLICE_W];
    assign c7   = w_c[SLICE_W-1];

endmodule

// File: rtl/cla_addsub_seq.sv
// Multi-cycle WIDTH-bit add/subtract: one byte per cycle through a shared
// 8-bit CLA slice, LSB first, with valid/ready handshakes on both sides.
module cla_addsub_seq
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NSLICE = WIDTH / 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int                IDX_W    = idx_width(NSLICE);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NSLICE - 1);

    addsub_state_t      r_state;
    addsub_state_t      w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;
    logic               r_overflow;
    logic               r_zero;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [SLICE_W-1:0] w_a_byte;
    logic [SLICE_W-1:0] w_b_byte;
    logic [SLICE_W-1:0] w_sum;
    logic               w_cout;
    logic               w_c7;
    logic [WIDTH-1:0]   w_assembled;
    logic               w_last;

    assign w_a_byte = r_a[r_idx*SLICE_W +: SLICE_W];
    assign w_b_byte = r_b[r_idx*SLICE_W +: SLICE_W];
    assign w_last   = (r_idx == IDX_LAST);

    cla_slice_8 u_slice (
        .a    (w_a_byte),
        .b    (w_b_byte),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout),
        .c7   (w_c7)
    );

    // Result as it will look once the current byte is written back.
    always_comb begin
        w_assembled = r_result;
        w_assembled[r_idx*SLICE_W +: SLICE_W] = w_sum;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_next = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end else begin
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register and handshake outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == IDLE);
            r_out_valid <= (w_next == DONE);
        end
    end

    // Operand latch, byte-serial accumulation and final flag capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_carry     <= 1'b0;
            r_idx       <= {IDX_W{1'b0}};
            r_result    <= {WIDTH{1'b0}};
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub;
                        r_idx   <= {IDX_W{1'b0}};
                    end
                end
                RUN: begin
                    r_result[r_idx*SLICE_W +: SLICE_W] <= w_sum;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IDX_ONE;
                    if (w_last) begin
                        r_carry_out <= w_cout;
                        r_overflow  <= w_c7 ^ w_cout;
                        r_zero      <= (w_assembled == {WIDTH{1'b0}});
                    end
                end
                DONE: begin
                    r_idx <= {IDX_W{1'b0}};
                end
                default: begin
                    r_idx <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule

// File: tb/tb_cla_addsub_seq.sv
// Self-checking bench for cla_addsub_seq: directed table, random operations
// against an arithmetic reference model, back-pressure and mid-run reset.
module tb_cla_addsub_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    int checks = 0;
    int errors = 0;

    cla_addsub_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsub;
        logic [W-1:0] exp_res;
        logic         exp_c;
        logic         exp_v;
        logic         exp_z;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: integer arithmetic on unsigned and signed interpretations.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                                  output logic [W-1:0] r, output logic c, output logic v,
                                  output logic z);
        longint ua, ub, sa, sb, sr;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (ms) begin
            r  = W'(ua - ub);
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = W'(ua + ub);
            c  = ((ua + ub) >= (64'd1 << W));
            sr = sa + sb;
        end
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        z = (r == {W{1'b0}});
    endfunction

    // Present a request, scramble operands after acceptance, wait for out_valid.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                         input string nm);
        int lat;
        @(negedge clk);
        check({nm, " in_ready_before"}, 64'(in_ready), 64'd1);
        a = ta; b = tb; sub = ts; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({nm, " latency"}, 64'(lat), 64'd4);
    endtask

    task automatic expect_out(input string nm, input logic [W-1:0] er, input logic ec,
                              input logic ev, input logic ez);
        check({nm, " result"}, 64'(result), 64'(er));
        check({nm, " carry"}, 64'(carry_out), 64'(ec));
        check({nm, " ovf"}, 64'(overflow), 64'(ev));
        check({nm, " zero"}, 64'(zero), 64'(ez));
    endtask

    task automatic release_out(input string nm);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({nm, " out_valid_drop"}, 64'(out_valid), 64'd0);
        check({nm, " in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [W-1:0] er;
        logic ec, ev, ez;
        logic [W-1:0] ra, rb;
        logic rs;

        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 32'd0; b = 32'd0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst result", 64'(result), 64'd0);
        check("rst flags", 64'({carry_out, overflow, zero}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].va, vecs[i].vb, vecs[i].vsub, $sformatf("vec%0d", i));
            expect_out($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_c,
                       vecs[i].exp_v, vecs[i].exp_z);
            release_out($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom; rs = $urandom_range(0, 1);
            if (i % 8 == 0) rb = ra;
            model(ra, rb, rs, er, ec, ev, ez);
            issue(ra, rb, rs, $sformatf("rnd%0d", i));
            expect_out($sformatf("rnd%0d", i), er, ec, ev, ez);
            release_out($sformatf("rnd%0d", i));
        end

        // Back-pressure: result must hold while inputs churn.
        model(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1, er, ec, ev, ez);
        issue(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1, "bp");
        for (int k = 0; k < 3; k++) begin
            in_valid = ~in_valid; a = $urandom; b = $urandom;
            @(posedge clk);
            #1;
            expect_out($sformatf("bp%0d", k), er, ec, ev, ez);
            check($sformatf("bp%0d in_ready", k), 64'(in_ready), 64'd0);
            check($sformatf("bp%0d out_valid", k), 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        release_out("bp");
        @(posedge clk);
        #1;
        check("bp no_accept", 64'(out_valid), 64'd0);

        // Reset while the byte index is 2.
        @(negedge clk);
        a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst out_valid", 64'(out_valid), 64'd0);
        check("mid_rst in_ready", 64'(in_ready), 64'd1);
        check("mid_rst result", 64'(result), 64'd0);
        check("mid_rst flags", 64'({carry_out, overflow, zero}), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check("mid_rst no_pulse", 64'(out_valid), 64'd0);
        issue(32'd3, 32'd4, 1'b0, "post_rst");
        expect_out("post_rst", 32'd7, 1'b0, 1'b0, 1'b0);
        release_out("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_addsub_seq.md
Name: cla_addsub_seq

Overview:
- Multi-cycle WIDTH-bit adder/subtractor with valid/ready handshakes on input and output.
- Reuses a single 8-bit carry-lookahead slice iteratively: one byte per cycle, LSB first, with the carry registered between bytes.
- Provides the subtract direction (two's complement) alongside add, plus status flags.
- Sits between operand producers and the result consumer in the CLA datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 8 and at least 8.
- NSLICE, WIDTH/8, number of byte iterations (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand request valid
- in_ready  out  1  block can accept an operand request
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0: A+B, 1: A-B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  sum/difference
- carry_out  out  1  carry out of MSB (for sub: 1 = no borrow, A>=B unsigned)
- overflow  out  1  signed overflow
- zero  out  1  result == 0

Behaviour:
- Reset (checked on clk edge while rst=1):
  - state=IDLE; in_ready=1; out_valid=0; result, carry_out, overflow and zero all 0; byte index=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a_r=a, b_r = sub ? ~b : b, carry_r=sub, idx=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the slice computes byte idx of a_r + b_r + carry_r.
  - result[8*idx+:8] <= slice sum; carry_r <= slice cout; idx <= idx+1.
  - On idx==NSLICE-1, additionally:
    - carry_out <= slice cout
    - overflow <= slice carry-into-bit7 XOR slice cout
    - zero <= (assembled result == 0)
    - go to DONE.
- DONE:
  - out_valid=1; result and flags held stable.
  - On out_ready: go to IDLE. in_ready returns high the following cycle; there is no same-cycle accept in DONE.
- Latency: with acceptance on edge k, out_valid is high from edge k+NSLICE (4 cycles for WIDTH=32).
- Throughput: at most one operation per NSLICE+2 cycles.
- in_valid and operand changes while not in IDLE are ignored. Latched operands are immune to input changes after acceptance.
- out_ready while not in DONE is ignored.
- Back-pressure: out_valid stays asserted with result and flags unchanged until out_ready.
- Reset mid-operation (RUN or DONE): the operation is abandoned, all outputs take their reset values, and no out_valid pulse occurs.
- Arithmetic is modulo 2^WIDTH.
  - Subtraction is A + ~B + 1.
  - carry_out and overflow follow the standard two's-complement definitions for the full WIDTH, not per byte.
- Partial result bytes are written into result during RUN. Consumers must only sample result when out_valid=1.

Decomposition:
- Shared package cla_pkg:
  - SLICE_W=8 constant
  - state enum addsub_state_t {IDLE, RUN, DONE}
  - function computing the idx width as $clog2(NSLICE), minimum 1
- Sub-module cla_slice_8: purely combinational 8-bit CLA.
  - Inputs: a[8], b[8], cin. Outputs: sum[8], cout, c7 (carry into bit 7).
  - Built from per-bit p/g and carry lookahead logic of the existing style.
  - Instantiated once in cla_addsub_seq.

Test Plan:
- Add 0x0000_00FF + 0x0000_0001 -> result 0x0000_0100, carry_out 0, overflow 0, zero 0; out_valid exactly 4 cycles after acceptance.
- Add 0x7FFF_FFFF + 0x0000_0001 -> 0x8000_0000, overflow 1, carry_out 0. Add 0xFFFF_FFFF + 1 -> 0x0000_0000, carry_out 1, zero 1, overflow 0.
- Sub 5-7 -> 0xFFFF_FFFE, carry_out 0 (borrow), overflow 0. Sub 7-5 -> 0x0000_0002, carry_out 1. Sub 0x8000_0000-1 -> 0x7FFF_FFFF, overflow 1. Sub 0x1234_5678-0x1234_5678 -> 0, zero 1, carry_out 1.
- Back-pressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid and a/b -> result and flags stable, in_ready 0, no new acceptance. Then out_ready=1 -> IDLE, in_ready=1 on the next cycle.
- Operand change after acceptance: drive a new a/b in the cycle after acceptance -> result reflects the originally latched operands.
- Reset asserted at RUN idx=2 -> next cycle out_valid 0, in_ready 1, result 0, flags 0. A following request 3+4 completes normally to 7.
